// File: rtl/gate_pattern_checker.sv
// Drives all four input combinations into a NAND/NOR pair under test,
// compares the responses and accumulates a saturating mismatch count.
module gate_pattern_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y_nand,
    input  logic             y_nor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int unsigned EW1 = ERR_W + 1;
    localparam logic [7:0] HLAST = 8'(HOLD_CYCLES - 1);
    localparam logic [EW1-1:0] ERR_MAX = {1'b0, {ERR_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [7:0]       hcnt_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       fail_q;

    logic             mis_nand;
    logic             mis_nor;
    logic [1:0]       nmis;
    logic [EW1-1:0]   err_sum;
    logic [ERR_W-1:0] err_d;
    logic [3:0]       fail_d;

    // Score the gate responses against the currently driven stimulus.
    always_comb begin
        mis_nand = y_nand != ~(a_q & b_q);
        mis_nor  = y_nor != ~(a_q | b_q);
        nmis     = {1'b0, mis_nand} + {1'b0, mis_nor};
        err_sum  = {1'b0, err_q} + EW1'(nmis);
        err_d    = err_sum[ERR_W-1:0];
        if (err_sum > ERR_MAX) begin
            err_d = ERR_MAX[ERR_W-1:0];
        end
        fail_d = fail_q;
        if (nmis != 2'd0) begin
            fail_d = fail_q | (4'b0001 << idx_q);
        end
    end

    // Sequencer: step patterns, hold each, record results at compare edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            hcnt_q  <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= APPLY;
                        idx_q   <= 2'd0;
                        hcnt_q  <= 8'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= 4'd0;
                    end
                end
                APPLY: begin
                    if (hcnt_q == HLAST) begin
                        err_q  <= err_d;
                        fail_q <= fail_d;
                        hcnt_q <= 8'd0;
                        if (idx_q == 2'd3) begin
                            state_q <= DONE;
                            idx_q   <= 2'd0;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            {a_q, b_q} <= idx_q + 2'd1;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Directed bench for gate_pattern_checker: three instances cover the
// default build, a narrow error counter and single-cycle hold.
module tb_gate_pattern_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] av, bv, busyv, donev, passv;
    logic [2:0] yn, yr;
    logic [2:0] inv = 3'b000;
    logic [2:0] stuck = 3'b000;
    logic [3:0] e0, e2;
    logic [1:0] e1;
    logic [3:0] f0, f1, f2;
    logic [3:0] errv [3];
    logic [3:0] failv [3];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Behavioural gates under test with injectable faults.
    assign yn = ~(av & bv) ^ inv;
    assign yr = (~(av | bv) ^ inv) & ~stuck;

    assign errv[0]  = e0;
    assign errv[1]  = {2'b00, e1};
    assign errv[2]  = e2;
    assign failv[0] = f0;
    assign failv[1] = f1;
    assign failv[2] = f2;

    gate_pattern_checker #(.HOLD_CYCLES(4), .ERR_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(av[0]), .b(bv[0]), .y_nand(yn[0]), .y_nor(yr[0]),
        .busy(busyv[0]), .done(donev[0]), .pass(passv[0]),
        .err_count(e0), .fail_vec(f0)
    );

    gate_pattern_checker #(.HOLD_CYCLES(4), .ERR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(av[1]), .b(bv[1]), .y_nand(yn[1]), .y_nor(yr[1]),
        .busy(busyv[1]), .done(donev[1]), .pass(passv[1]),
        .err_count(e1), .fail_vec(f1)
    );

    gate_pattern_checker #(.HOLD_CYCLES(1), .ERR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(av[2]), .b(bv[2]), .y_nand(yn[2]), .y_nor(yr[2]),
        .busy(busyv[2]), .done(donev[2]), .pass(passv[2]),
        .err_count(e2), .fail_vec(f2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " ab"}, {30'd0, av[d], bv[d]}, 32'd0);
        chk({tag, " busy/done/pass"},
            {29'd0, busyv[d], donev[d], passv[d]}, 32'd0);
        chk({tag, " err"}, {28'd0, errv[d]}, 32'd0);
        chk({tag, " fail"}, {28'd0, failv[d]}, 32'd0);
    endtask

    // One full run on instance d; optionally re-pulse start mid-run.
    task automatic run(input int d, input int hold,
                       input logic [3:0] x_err, input logic [3:0] x_fail,
                       input logic x_pass, input bit repulse,
                       input string tag);
        int nb;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        chk({tag, " start busy/done/pass"},
            {29'd0, busyv[d], donev[d], passv[d]}, 32'd4);
        chk({tag, " start err"}, {28'd0, errv[d]}, 32'd0);
        chk({tag, " start fail"}, {28'd0, failv[d]}, 32'd0);
        nb = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busyv[d]) break;
            if (k < 4 * hold)
                chk($sformatf("%s ab k=%0d", tag, k),
                    {30'd0, av[d], bv[d]}, 32'(k / hold));
            chk($sformatf("%s done k=%0d", tag, k),
                {31'd0, donev[d]}, 32'd0);
            nb++;
            start_v[d] = repulse && (k == 3 || k == 9);
            @(posedge clk);
            #1;
        end
        start_v[d] = 1'b0;
        chk({tag, " busy cycles"}, 32'(nb), 32'(4 * hold));
        chk({tag, " done"}, {31'd0, donev[d]}, 32'd1);
        chk({tag, " pass"}, {31'd0, passv[d]}, {31'd0, x_pass});
        chk({tag, " err"}, {28'd0, errv[d]}, {28'd0, x_err});
        chk({tag, " fail"}, {28'd0, failv[d]}, {28'd0, x_fail});
        chk({tag, " ab end"}, {30'd0, av[d], bv[d]}, 32'd0);
    endtask

    initial begin
        #2;
        for (int d = 0; d < 3; d++) chk_idle(d, $sformatf("reset%0d", d));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle(0, "post-reset idle");

        run(0, 4, 4'd0, 4'b0000, 1'b1, 1'b0, "good");
        repeat (3) @(posedge clk);
        #1;
        chk("hold done", {31'd0, donev[0]}, 32'd1);
        chk("hold pass", {31'd0, passv[0]}, 32'd1);

        stuck[0] = 1'b1;
        run(0, 4, 4'd1, 4'b0001, 1'b0, 1'b0, "nor0");
        repeat (2) @(posedge clk);
        #1;
        chk("nor0 hold err", {28'd0, errv[0]}, 32'd1);
        chk("nor0 hold fail", {28'd0, failv[0]}, 32'd1);

        inv[1] = 1'b1;
        run(1, 4, 4'd3, 4'b1111, 1'b0, 1'b0, "sat");

        stuck[0] = 1'b0;
        run(0, 4, 4'd0, 4'b0000, 1'b1, 1'b1, "repulse");

        run(2, 1, 4'd0, 4'b0000, 1'b1, 1'b0, "hold1");

        stuck[0] = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort pre ab", {30'd0, av[0], bv[0]}, 32'd2);
        chk("abort pre err", {28'd0, errv[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(0, "abort");
        chk("abort busy/done", {30'd0, busyv[0], donev[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stuck[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle(0, "abort idle");
        run(0, 4, 4'd0, 4'b0000, 1'b1, 1'b0, "clean");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/gate_pattern_checker.md
GATE_PATTERN_CHECKER -- requirements
Module: gate_pattern_checker

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, cycles each input combination is held (legal range 1..255).
REQ-002 The block SHALL have parameter ERR_W, default 4, width of the error counter (legal range 2..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle run request, honoured in IDLE or DONE only.
REQ-006 The block SHALL have port a  output  1  registered stimulus A to the NAND/NOR gates under test.
REQ-007 The block SHALL have port b  output  1  registered stimulus B to the NAND/NOR gates under test.
REQ-008 The block SHALL have port y_nand  input  1  NAND gate response.
REQ-009 The block SHALL have port y_nor  input  1  NOR gate response.
REQ-010 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-011 The block SHALL have port done  output  1  high from run completion until the next start or reset.
REQ-012 The block SHALL have port pass  output  1  valid while done is high; 1 = zero mismatches.
REQ-013 The block SHALL have port err_count  output  ERR_W  saturating mismatch count for the current or last run.
REQ-014 The block SHALL have port fail_vec  output  4  bit i set = combination i ({a,b}=i) had at least one mismatch.

Function
REQ-015 The block SHALL implement states IDLE, APPLY and DONE.
REQ-016 On a start sampled high in IDLE or DONE, the block SHALL, at that edge: enter APPLY; set pattern index idx=0 and hold counter hcnt=0; drive a=0, b=0; clear err_count and fail_vec; set busy=1, done=0, pass=0.
REQ-017 In APPLY, a SHALL equal idx[1] and b SHALL equal idx[0]; idx SHALL step 0,1,2,3 (00,01,10,11) with no other order.
REQ-018 In APPLY, hcnt SHALL increment each cycle; on the cycle where hcnt==HOLD_CYCLES-1 (compare cycle), y_nand and y_nor SHALL be sampled at the closing edge.
REQ-019 The expected values SHALL be y_nand = ~(a&b) and y_nor = ~(a|b), evaluated on the currently driven a and b.
REQ-020 At each compare edge, err_count SHALL increase by the number of mismatching outputs (0, 1 or 2), saturating at 2^ERR_W-1 with no wrap.
REQ-021 At each compare edge with any mismatch, fail_vec[idx] SHALL be set; fail_vec bits SHALL never clear within a run.
REQ-022 At a compare edge with idx<3, the block SHALL set idx=idx+1 and hcnt=0, and a/b SHALL update at that same edge.
REQ-023 At the compare edge with idx==3, the block SHALL enter DONE, set busy=0 and done=1, set pass=1 iff the final err_count is 0, and return a and b to 0.
REQ-024 Run length SHALL be exactly 4*HOLD_CYCLES cycles with busy=1; done SHALL rise on the edge that ends the last compare cycle.
REQ-025 A start while busy=1 SHALL be ignored, with no restart and no effect on the counters.
REQ-026 In DONE, err_count, fail_vec and pass SHALL hold until the next start, which restarts the run per REQ-016.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from y_nand or y_nor to any output.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0 and hcnt=0, independent of clk.
REQ-029 An rst_n assertion mid-run SHALL abort the run with no partial result retained; after rst_n deassertion the block SHALL wait in IDLE for start.

Verification
REQ-030 The bench SHALL cover: correct gates, HOLD_CYCLES=4, start pulse -> a,b step 00,01,10,11 every 4 cycles; busy high for 16 cycles; then done=1, pass=1, err_count=0, fail_vec=0000.
REQ-031 The bench SHALL cover: y_nor stuck at 0 -> after the run pass=0, err_count=1, fail_vec=0001.
REQ-032 The bench SHALL cover: y_nand and y_nor both inverted, ERR_W=2 -> err_count saturates at 3, fail_vec=1111, pass=0.
REQ-033 The bench SHALL cover: start re-pulsed at cycles 3 and 9 of a run -> ignored; done still rises after exactly 16 busy cycles.
REQ-034 The bench SHALL cover: rst_n pulled low during idx=2 with a mismatch already counted -> all outputs 0 at once; a later start gives a clean run with pass=1.
REQ-035 The bench SHALL cover: HOLD_CYCLES=1 -> a new pattern every cycle, busy for 4 cycles, results identical to REQ-030.
